descrambler_64b66b_rx: RTL and testbench

Self-synchronising 64b/66b descrambler for the PCS receive path, polynomial 1 + x^39 + x^58. It sits after block sync and header strip and recovers the payload that the transmit scrambler produced. It processes LEN payload bits per valid beat. It keeps the last 58 received (scrambled) bits as history and tracks history fill, so downstream logic knows when output is trustworthy after reset or resync.

---
 rtl/descrambler_64b66b_rx.sv | 106 ++++++++++
 tb/tb_descrambler_64b66b_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/descrambler_64b66b_rx.sv
// Purpose : self-synchronising 64b/66b descrambler (1 + x^39 + x^58), LEN payload bits per beat, with history-fill lock.
// Latency : 0 cycles (combinational data/valid); 1 cycle when DESCRAM_OUT_REG_EN is defined. lock_o is always registered.
// Backpressure: none; every valid_i beat is consumed, one beat per clk.
module descrambler_64b66b_rx #(
    parameter int LEN = 32
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           valid_i,
    input  logic           resync_i,
    input  logic [LEN-1:0] data_i,
    output logic           valid_o,
    output logic [LEN-1:0] data_o,
    output logic           lock_o
);

    localparam int HIST = 58;
    localparam int TAP  = 39;

    // s_q[0] is the newest received bit, s_q[57] the oldest
    logic [HIST-1:0]     s_q;
    logic [HIST-1:0]     s_d;
    // Received-bit stream in wire order: ext[HIST+j] = h(j), so ext[0] = h(-58)
    logic [LEN+HIST-1:0] ext;
    logic [LEN-1:0]      descr;
    logic [5:0]          fill_q;
    logic [5:0]          fill_d;
    logic [6:0]          fill_sum;
    logic                lock_q;

    // Lay history (oldest first) and the new beat out as one bit stream
    always_comb begin
        ext = '0;
        for (int k = 0; k < HIST; k++) begin
            ext[k] = s_q[HIST-1-k];
        end
        ext[LEN+HIST-1:HIST] = data_i;
    end

    // Descramble: each output bit cancels the two scrambler taps 39 and 58 bits back
    always_comb begin
        descr = '0;
        for (int i = 0; i < LEN; i++) begin
            descr[i] = data_i[i] ^ ext[i+HIST-TAP] ^ ext[i];
        end
    end

    // Next history is the newest 58 bits of the stream, newest at index 0
    always_comb begin
        s_d = '0;
        for (int k = 0; k < HIST; k++) begin
            s_d[k] = ext[LEN+HIST-1-k];
        end
    end

    // Fill tracking: resync wins over a concurrent beat; saturates at 58
    always_comb begin
        fill_sum = {1'b0, fill_q} + 7'(LEN);
        fill_d   = fill_q;
        if (resync_i) begin
            fill_d = '0;
        end else if (valid_i) begin
            fill_d = (fill_sum >= 7'(HIST)) ? 6'(HIST) : fill_sum[5:0];
        end
    end

    // History, fill counter and lock flop; lock tracks the post-edge fill value
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s_q    <= '1;
            fill_q <= '0;
            lock_q <= 1'b0;
        end else begin
            if (valid_i) begin
                s_q <= s_d;
            end
            fill_q <= fill_d;
            lock_q <= (fill_d == 6'(HIST));
        end
    end

    assign lock_o = lock_q;

`ifdef DESCRAM_OUT_REG_EN
    logic           valid_q;
    logic [LEN-1:0] data_q;

    // Output register isolates the deep XOR cone from the pins
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i;
            data_q  <= descr;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
`else
    assign valid_o = valid_i;
    assign data_o  = descr;
`endif

endmodule

// File: tb/tb_descrambler_64b66b_rx.sv
// Purpose : randomized + directed bench for descrambler_64b66b_rx against a bit-stream model.
// Latency : follows DESCRAM_OUT_REG_EN (0 or 1 cycle) like the design.
// Backpressure: none exercised; the design has none.
module tb_descrambler_64b66b_rx;

    localparam int LEN = 32;

    logic           clk = 1'b0;
    logic           nreset = 1'b0;
    logic           valid_i = 1'b0;
    logic           resync_i = 1'b0;
    logic [LEN-1:0] data_i = '0;
    logic           valid_o;
    logic [LEN-1:0] data_o;
    logic           lock_o;

    descrambler_64b66b_rx #(.LEN(LEN)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .valid_i  (valid_i),
        .resync_i (resync_i),
        .data_i   (data_i),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .lock_o   (lock_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef DESCRAM_OUT_REG_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    // Model state: received-bit history oldest first, bits received since sync
    bit             hist_m[$];
    int             fill_m;
    logic           exp_vld_r;
    logic [LEN-1:0] exp_dat_r;
    // Transmit scrambler history (scrambled bits, oldest first)
    bit             tx_m[$];
    logic [LEN-1:0] obs_q[$];
    logic [LEN-1:0] pay_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // out[i] = d[i] ^ h(i-39) ^ h(i-58) over the received stream w, where w[58+j] = h(j)
    function automatic logic [LEN-1:0] descr_model(input logic [LEN-1:0] d);
        bit w[$];
        logic [LEN-1:0] r;
        w = hist_m;
        for (int i = 0; i < LEN; i++) w.push_back(d[i]);
        r = '0;
        for (int i = 0; i < LEN; i++) r[i] = d[i] ^ w[i+19] ^ w[i];
        return r;
    endfunction

    // Reference model: reacts to reset asynchronously, accepts beats on the rising edge
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hist_m.delete();
            for (int k = 0; k < 58; k++) hist_m.push_back(1'b1);
            fill_m    = 0;
            exp_vld_r = 1'b0;
            exp_dat_r = '0;
        end else begin
            exp_vld_r = valid_i;
            exp_dat_r = descr_model(data_i);
            if (valid_i) begin
                for (int i = 0; i < LEN; i++) begin
                    hist_m.push_back(data_i[i]);
                    void'(hist_m.pop_front());
                end
            end
            if (resync_i) fill_m = 0;
            else if (valid_i) fill_m = (fill_m + LEN > 58) ? 58 : fill_m + LEN;
        end
    end

    // Compare process: every falling edge, outputs against the model
    always @(negedge clk) begin
        logic           evld;
        logic [LEN-1:0] edat;
        if (REG_OUT) begin
            evld = exp_vld_r;
            edat = exp_dat_r;
        end else begin
            evld = valid_i;
            edat = descr_model(data_i);
        end
        chk("valid_o", 64'(valid_o), 64'(evld));
        if (evld) chk("data_o", 64'(data_o), 64'(edat));
        if (valid_o === 1'b1) obs_q.push_back(data_o);
        chk("lock_o", 64'(lock_o), 64'(fill_m == 58));
    end

    task automatic beat(input logic rs, input logic [LEN-1:0] d);
        valid_i  = 1'b1;
        resync_i = rs;
        data_i   = d;
        @(posedge clk); #1;
        valid_i  = 1'b0;
        resync_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i  = 1'b0;
        resync_i = 1'b0;
        repeat (n) begin
            data_i = $urandom;
            @(posedge clk); #1;
        end
    endtask

    task automatic tx_reset();
        tx_m.delete();
        for (int k = 0; k < 58; k++) tx_m.push_back(1'b1);
    endtask

    // Scramble a random payload (s = p ^ s[-39] ^ s[-58]) and send it
    task automatic tx_beat(input logic rs);
        logic [LEN-1:0] p;
        logic [LEN-1:0] sc;
        bit s;
        p = $urandom;
        for (int i = 0; i < LEN; i++) begin
            s = p[i] ^ tx_m[19] ^ tx_m[0];
            sc[i] = s;
            tx_m.push_back(s);
            void'(tx_m.pop_front());
        end
        pay_q.push_back(p);
        beat(rs, sc);
    endtask

    task automatic apply_reset();
        nreset   = 1'b0;
        valid_i  = 1'b0;
        resync_i = 1'b0;
        repeat (2) @(posedge clk);
        #3 nreset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and the two hand-computed first beats
        apply_reset();
        chk("reset_valid_o", 64'(valid_o), 64'(1'b0));
        chk("reset_lock_o", 64'(lock_o), 64'(1'b0));
        if (REG_OUT) chk("reset_data_o", 64'(data_o), 64'(0));
        obs_q.delete();
        beat(1'b0, 32'h0000_0000);
        chk("lock_after_beat1", 64'(lock_o), 64'(1'b0));
        beat(1'b0, 32'hFFFF_FFFF);
        chk("lock_after_beat2", 64'(lock_o), 64'(1'b1));
        idle(2);
        chk("first_beats_count", 64'(obs_q.size()), 64'(2));
        if (obs_q.size() >= 2) begin
            chk("first_beat_zero", 64'(obs_q[0]), 64'(32'h0000_0000));
            chk("second_beat_ones", 64'(obs_q[1]), 64'(32'hFC00_007F));
        end

        // Loopback from an all-ones-seeded scrambler with random gaps
        apply_reset();
        tx_reset();
        obs_q.delete();
        pay_q.delete();
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            tx_beat(1'b0);
        end
        // Resync together with a beat, then relock after two more
        tx_beat(1'b1);
        chk("lock_after_resync", 64'(lock_o), 64'(1'b0));
        tx_beat(1'b0);
        chk("lock_resync_plus1", 64'(lock_o), 64'(1'b0));
        tx_beat(1'b0);
        chk("lock_resync_plus2", 64'(lock_o), 64'(1'b1));
        // Five idle cycles leave lock and history untouched
        for (int g = 0; g < 5; g++) begin
            idle(1);
            chk("lock_in_gap", 64'(lock_o), 64'(1'b1));
        end
        tx_beat(1'b0);
        tx_beat(1'b0);
        idle(2);
        chk("loopback_count", 64'(obs_q.size()), 64'(pay_q.size()));
        for (int k = 0; k < pay_q.size() && k < obs_q.size(); k++) begin
            chk("loopback_payload", 64'(obs_q[k]), 64'(pay_q[k]));
        end

        // Self-sync: history forced to zero, transmitter restarts from all ones
        beat(1'b0, 32'h0);
        beat(1'b0, 32'h0);
        idle(2);
        obs_q.delete();
        pay_q.delete();
        tx_reset();
        tx_beat(1'b1);
        for (int n = 0; n < 19; n++) tx_beat(1'b0);
        idle(2);
        chk("selfsync_count", 64'(obs_q.size()), 64'(20));
        for (int k = 2; k < 20 && k < obs_q.size(); k++) begin
            chk("selfsync_payload", 64'(obs_q[k]), 64'(pay_q[k]));
        end

        // Asynchronous reset in the middle of a beat, no clock edge
        beat(1'b0, $urandom);
        valid_i = 1'b1;
        data_i  = $urandom;
        #2 nreset = 1'b0;
        #1;
        chk("async_lock_o", 64'(lock_o), 64'(1'b0));
        if (REG_OUT) begin
            chk("async_valid_o", 64'(valid_o), 64'(1'b0));
            chk("async_data_o", 64'(data_o), 64'(0));
        end
        valid_i = 1'b0;
        @(posedge clk);
        #3 nreset = 1'b1;
        @(posedge clk); #1;
        obs_q.delete();
        valid_i = 1'b1;
        data_i  = 32'h0;
        #3;
        chk("latency_same_cycle", 64'(valid_o), 64'(!REG_OUT));
        @(posedge clk); #1;
        valid_i = 1'b0;
        #3;
        chk("latency_next_cycle", 64'(valid_o), 64'(REG_OUT));
        idle(2);
        chk("post_reset_count", 64'(obs_q.size()), 64'(1));
        if (obs_q.size() >= 1) chk("post_reset_zero", 64'(obs_q[0]), 64'(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
